ps2_paddle_keys: RTL and testbench
==================================

Name: ps2_paddle_keys

Overview:
- Upstream input stage for GameLogic. Replaces the board push buttons with a PS/2 keyboard.
- Receives PS/2 device-to-host frames on PS2_CLK/PS2_DAT and decodes make/break/extended scan codes.
- Holds the pressed state of four paddle keys and drives them on keys_left/keys_right. Polarity is the same as the DE2-115 KEY inputs, so the block drops in where KEY[3:0] is wired today.

Parameters:
- FILTER_LEN, 8, number of consecutive equal samples of synchronised ps2_clk needed before the filtered clock changes.
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock, CLOCK2_50 domain.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS2_CLK pad, asynchronous.
- ps2_dat  input  1  raw PS2_DAT pad, asynchronous.
- keys_left  output  2  active-low; [1]=W (up), [0]=S (down).
- keys_right  output  2  active-low; [1]=Up arrow, [0]=Down arrow.
- scan_code  output  8  last correctly received byte.
- scan_valid  output  1  one-cycle pulse when scan_code updates.
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error.

Behaviour:
- Reset values (async, rst_n=0): keys_left=2'b11, keys_right=2'b11, scan_code=8'h00, scan_valid=0, frame_err=0. Receiver returns to IDLE; decoder flags brk=0, ext=0; filtered clk=1; timeout counter=0.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - Filtered clk takes the synchronised value only after FILTER_LEN consecutive identical samples. Pulses shorter than that are ignored.
  - A bit is sampled from synchronised ps2_dat on the clk cycle the filtered clk goes 1->0.
- Receiver FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on an edge with dat=0, go to DATA with bit count 0. An edge with dat=1 is ignored and raises no error.
  - DATA: shift 8 bits, LSB first. Go to PARITY after the 8th bit.
  - PARITY: store the parity bit, go to STOP.
  - STOP: on the edge, go to IDLE. The frame is good if the data bits plus parity bit have odd weight and the stop bit is 1.
  - Good frame: one cycle after the stop-bit edge, scan_code gets the byte and scan_valid=1 for exactly one cycle.
  - Bad frame: frame_err=1 for one cycle in the same slot. scan_code is held and the decoder is not invoked.
- Timeout:
  - The counter clears on every sampled edge and counts in any state other than IDLE.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, frame_err pulses once, and brk/ext clear.
  - The counter saturates in IDLE, so there is no repeated error.
- Decoder (acts on the same cycle scan_valid is asserted):
  - 8'hF0: brk=1.
  - 8'hE0: ext=1.
  - Any other code: if (ext, code) matches a table entry, the mapped key bit is set to brk (make -> 0, break -> 1). Then brk=0 and ext=0, whether or not the code matched.
  - Table: (0,1D) -> keys_left[1]; (0,1B) -> keys_left[0]; (1,75) -> keys_right[1]; (1,72) -> keys_right[0].
  - Non-extended 75/72 (keypad) and extended 1D/1B are ignored.
  - A frame error clears brk/ext.
- Typematic repeats of a make code re-write 0 with no visible change.
- Both keys of one paddle held gives 2'b00, passed through unfiltered; GameLogic arbitrates.
- Outputs are registered. No combinational path from the ps2 pins to any output.
- Reset mid-frame: immediate return to reset values. A frame already in flight is discarded. The next complete frame decodes normally.

Test Plan:
1. Frame 1D (parity 1), then frames F0, 1D -> after first frame keys_left=2'b01, scan_code=8'h1D, scan_valid high one cycle; after break keys_left=2'b11, scan_valid pulsed 3 times total.
2. E0,75 then E0,F0,75, then plain 75 -> keys_right 2'b01, then 2'b11, then still 2'b11 (keypad ignored); keys_left stays 2'b11 throughout.
3. Frame 1B with wrong parity bit (0) -> frame_err one pulse, no scan_valid, scan_code unchanged, keys unchanged; next correct 1B -> keys_left=2'b10.
4. Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10 -> exactly one frame_err pulse; next full frame 72 preceded by E0 -> keys_right=2'b10.
5. 3-cycle low glitches on ps2_clk injected between bits of frame 1D -> decoded byte still 8'h1D, no frame_err; with FILTER_LEN=8 a 7-cycle glitch is also rejected.
6. Make W received, then rst_n low for 2 cycles mid-frame -> keys_left=2'b11, scan_code=8'h00 asynchronously; after release a clean frame 1B -> keys_left=2'b10.

Source files
------------

// File: rtl/ps2_paddle_keys_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_paddle_keys_if
//  Description : PS/2 pad pins plus decoded paddle-key and scan-code outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_paddle_keys_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [1:0] keys_left;
    logic [1:0] keys_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  keys_left, keys_right, scan_code, scan_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output keys_left, keys_right, scan_code, scan_valid, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_paddle_keys.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_paddle_keys
//  Description : PS/2 keyboard receiver and scan-code decoder producing
//                active-low paddle keys (W/S left, Up/Down arrows right).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_paddle_keys #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire              clk,
    input  wire              rst_n,
    ps2_paddle_keys_if.slave bus
);

    localparam int c_FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_FCNT_W-1:0] c_FILT_LAST = c_FCNT_W'(FILTER_LEN - 1);
    localparam logic [c_TO_W-1:0]   c_TO_MAX    = c_TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    localparam logic [7:0] c_CODE_BREAK = 8'hF0;
    localparam logic [7:0] c_CODE_EXT   = 8'hE0;

    // ------------------------------------------------------------------
    // Input synchronisers (idle bus level is high)
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2_clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_dat};
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter: follow the synchronised clock only after
    // FILTER_LEN consecutive samples disagree with the filtered level.
    // ------------------------------------------------------------------
    logic [c_FCNT_W-1:0] r_filt_cnt;
    logic                r_clk_filt;
    logic                r_clk_filt_d;
    logic                w_filt_flip;
    logic                w_fall;

    assign w_filt_flip = (r_clk_sync[1] != r_clk_filt) && (r_filt_cnt == c_FILT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_filt_flip) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_timeout;
    logic              w_frame_done;
    logic              w_frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        w_frame_good = 1'b0;
        w_timeout    = (r_state != c_ST_IDLE) && !w_fall && (r_to_cnt == c_TO_MAX);
        if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_dat_sync[1]) begin
                        w_state_nxt = c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_ST_PARITY;
                    end
                end
                c_ST_PARITY: begin
                    w_state_nxt = c_ST_STOP;
                end
                c_ST_STOP: begin
                    w_state_nxt  = c_ST_IDLE;
                    w_frame_done = 1'b1;
                    // Odd parity over data+parity, and a high stop bit
                    w_frame_good = (^{r_shift, r_parity}) & r_dat_sync[1];
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
        end else if (w_fall && !w_timeout) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_bit_cnt <= 3'd0;
                end
                c_ST_DATA: begin
                    r_shift   <= {r_dat_sync[1], r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                c_ST_PARITY: begin
                    r_parity <= r_dat_sync[1];
                end
                default: begin
                end
            endcase
        end
    end

    // Counter parks at the limit in IDLE so a timeout is reported only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_fall) begin
            r_to_cnt <= '0;
        end else if ((r_state != c_ST_IDLE) && (r_to_cnt != c_TO_MAX)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame result registers
    // ------------------------------------------------------------------
    logic [7:0] r_scan_code;
    logic       r_scan_valid;
    logic       r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_code  <= 8'h00;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_scan_valid <= w_frame_done & w_frame_good;
            r_frame_err  <= (w_frame_done & ~w_frame_good) | w_timeout;
            if (w_frame_done && w_frame_good) begin
                r_scan_code <= r_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder and key state
    // ------------------------------------------------------------------
    logic       r_brk;
    logic       r_ext;
    logic [1:0] r_keys_left;
    logic [1:0] r_keys_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_keys_left  <= 2'b11;
            r_keys_right <= 2'b11;
        end else if (r_frame_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_scan_valid) begin
            if (r_scan_code == c_CODE_BREAK) begin
                r_brk <= 1'b1;
            end else if (r_scan_code == c_CODE_EXT) begin
                r_ext <= 1'b1;
            end else begin
                // Key level equals the break flag: make drives 0, break drives 1
                case ({r_ext, r_scan_code})
                    9'h01D:  r_keys_left[1]  <= r_brk;
                    9'h01B:  r_keys_left[0]  <= r_brk;
                    9'h175:  r_keys_right[1] <= r_brk;
                    9'h172:  r_keys_right[0] <= r_brk;
                    default: begin
                    end
                endcase
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    assign bus.keys_left  = r_keys_left;
    assign bus.keys_right = r_keys_right;
    assign bus.scan_code  = r_scan_code;
    assign bus.scan_valid = r_scan_valid;
    assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_paddle_keys.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_paddle_keys
//  Description : Self-checking bench for ps2_paddle_keys with a key-state model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_paddle_keys;

    localparam int c_FILTER_LEN = 8;
    localparam int c_TIMEOUT    = 2000;
    localparam int c_HALF       = 20;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ps2_paddle_keys_if bus ();

    ps2_paddle_keys #(
        .FILTER_LEN     (c_FILTER_LEN),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters sampled on the inactive edge
    int n_valid = 0;
    int n_err   = 0;
    always @(negedge clk) begin
        if (bus.scan_valid === 1'b1) n_valid++;
        if (bus.frame_err === 1'b1) n_err++;
    end

    // Reference model: key table applied to received bytes
    logic [1:0] m_left, m_right;
    logic [7:0] m_code;
    logic       m_brk, m_ext;
    int         m_valid = 0;
    int         m_err   = 0;

    function void model_reset();
        m_left = 2'b11; m_right = 2'b11; m_code = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
    endfunction

    function void model_error();
        m_err++; m_brk = 1'b0; m_ext = 1'b0;
    endfunction

    function void model_byte(input logic [7:0] b);
        m_valid++;
        m_code = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_ext && b == 8'h1D) m_left[1]  = m_brk;
            if (!m_ext && b == 8'h1B) m_left[0]  = m_brk;
            if ( m_ext && b == 8'h75) m_right[1] = m_brk;
            if ( m_ext && b == 8'h72) m_right[0] = m_brk;
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endfunction

    // bits[0] goes out first; optional ps2_clk low glitch during high phase
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_dat = bits[i];
            if (glitch > 0 && i > 0) begin
                repeat (4) @(negedge clk);
                bus.ps2_clk = 1'b0;
                repeat (glitch) @(negedge clk);
                bus.ps2_clk = 1'b1;
            end
            repeat (c_HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (c_HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        @(negedge clk);
        bus.ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({1'b1, par, b, 1'b0}, 11, glitch);
        repeat (30) @(negedge clk);
        if (bad_par) model_error();
        else model_byte(b);
    endtask

    task automatic test_reset();
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (bus.keys_left !== 2'b11) begin n_errors++; $display("FAIL rst_keys_left: got %b expected 11", bus.keys_left); end
        n_checks++; if (bus.keys_right !== 2'b11) begin n_errors++; $display("FAIL rst_keys_right: got %b expected 11", bus.keys_right); end
        n_checks++; if (bus.scan_code !== 8'h00) begin n_errors++; $display("FAIL rst_scan_code: got %h expected 00", bus.scan_code); end
        n_checks++; if ({bus.scan_valid, bus.frame_err} !== 2'b00) begin n_errors++; $display("FAIL rst_pulses: got %b expected 00", {bus.scan_valid, bus.frame_err}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make_break();
        int v0;
        v0 = n_valid;
        send_byte(8'h1D, 0, 0);
        n_checks++; if (bus.keys_left !== 2'b01) begin n_errors++; $display("FAIL mb_make_left: got %b expected 01", bus.keys_left); end
        n_checks++; if (bus.scan_code !== 8'h1D) begin n_errors++; $display("FAIL mb_scan_code: got %h expected 1d", bus.scan_code); end
        n_checks++; if (n_valid - v0 !== 1) begin n_errors++; $display("FAIL mb_valid_one: got %0d expected 1", n_valid - v0); end
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1D, 0, 0);
        n_checks++; if (bus.keys_left !== 2'b11) begin n_errors++; $display("FAIL mb_break_left: got %b expected 11", bus.keys_left); end
        n_checks++; if (n_valid - v0 !== 3) begin n_errors++; $display("FAIL mb_valid_three: got %0d expected 3", n_valid - v0); end
    endtask

    task automatic test_extended();
        send_byte(8'hE0, 0, 0);
        send_byte(8'h75, 0, 0);
        n_checks++; if (bus.keys_right !== 2'b01) begin n_errors++; $display("FAIL ext_make_right: got %b expected 01", bus.keys_right); end
        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h75, 0, 0);
        n_checks++; if (bus.keys_right !== 2'b11) begin n_errors++; $display("FAIL ext_break_right: got %b expected 11", bus.keys_right); end
        send_byte(8'h75, 0, 0);
        n_checks++; if (bus.keys_right !== 2'b11) begin n_errors++; $display("FAIL ext_keypad_right: got %b expected 11", bus.keys_right); end
        n_checks++; if (bus.keys_left !== 2'b11) begin n_errors++; $display("FAIL ext_left_idle: got %b expected 11", bus.keys_left); end
    endtask

    task automatic test_parity_err();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_byte(8'h1B, 1, 0);
        n_checks++; if (n_err - e0 !== 1) begin n_errors++; $display("FAIL par_err_pulse: got %0d expected 1", n_err - e0); end
        n_checks++; if (n_valid - v0 !== 0) begin n_errors++; $display("FAIL par_no_valid: got %0d expected 0", n_valid - v0); end
        n_checks++; if (bus.scan_code !== 8'h75) begin n_errors++; $display("FAIL par_scan_held: got %h expected 75", bus.scan_code); end
        n_checks++; if (bus.keys_left !== 2'b11) begin n_errors++; $display("FAIL par_keys_held: got %b expected 11", bus.keys_left); end
        send_byte(8'h1B, 0, 0);
        n_checks++; if (bus.keys_left !== 2'b10) begin n_errors++; $display("FAIL par_recover_left: got %b expected 10", bus.keys_left); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = n_err;
        send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 5, 0);
        repeat (c_TIMEOUT + 10) @(negedge clk);
        repeat (20) @(negedge clk);
        model_error();
        n_checks++; if (n_err - e0 !== 1) begin n_errors++; $display("FAIL to_err_once: got %0d expected 1", n_err - e0); end
        send_byte(8'hE0, 0, 0);
        send_byte(8'h72, 0, 0);
        n_checks++; if (bus.keys_right !== 2'b10) begin n_errors++; $display("FAIL to_recover_right: got %b expected 10", bus.keys_right); end
        n_checks++; if (n_err - e0 !== 1) begin n_errors++; $display("FAIL to_no_extra_err: got %0d expected 1", n_err - e0); end
    endtask

    task automatic test_glitch();
        int e0;
        e0 = n_err;
        send_byte(8'h1D, 0, 3);
        n_checks++; if (bus.scan_code !== 8'h1D) begin n_errors++; $display("FAIL gl3_scan_code: got %h expected 1d", bus.scan_code); end
        n_checks++; if (bus.keys_left[1] !== 1'b0) begin n_errors++; $display("FAIL gl3_w_pressed: got %b expected 0", bus.keys_left[1]); end
        send_byte(8'hF0, 0, c_FILTER_LEN - 1);
        send_byte(8'h1D, 0, c_FILTER_LEN - 1);
        n_checks++; if (bus.scan_code !== 8'h1D) begin n_errors++; $display("FAIL gl7_scan_code: got %h expected 1d", bus.scan_code); end
        n_checks++; if (bus.keys_left[1] !== 1'b1) begin n_errors++; $display("FAIL gl7_w_released: got %b expected 1", bus.keys_left[1]); end
        n_checks++; if (n_err - e0 !== 0) begin n_errors++; $display("FAIL gl_no_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h1D, 0, 0);
        n_checks++; if (bus.keys_left[1] !== 1'b0) begin n_errors++; $display("FAIL rm_w_pressed: got %b expected 0", bus.keys_left[1]); end
        send_bits({1'b1, 1'b0, 8'h1B, 1'b0}, 4, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.keys_left !== 2'b11) begin n_errors++; $display("FAIL rm_async_left: got %b expected 11", bus.keys_left); end
        n_checks++; if (bus.scan_code !== 8'h00) begin n_errors++; $display("FAIL rm_async_scan: got %h expected 00", bus.scan_code); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (30) @(negedge clk);
        send_byte(8'h1B, 0, 0);
        n_checks++; if (bus.keys_left !== 2'b10) begin n_errors++; $display("FAIL rm_after_left: got %b expected 10", bus.keys_left); end
        n_checks++; if (bus.scan_code !== 8'h1B) begin n_errors++; $display("FAIL rm_after_scan: got %h expected 1b", bus.scan_code); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         bad;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: b = 8'h1D;
                1: b = 8'h1B;
                2: b = 8'h75;
                3: b = 8'h72;
                4: b = 8'hF0;
                5: b = 8'hE0;
                6: b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 9) == 0);
            send_byte(b, bad, 0);
            n_checks++; if ({bus.keys_left, bus.keys_right} !== {m_left, m_right}) begin n_errors++; $display("FAIL rnd_keys[%0d]: got %b expected %b", i, {bus.keys_left, bus.keys_right}, {m_left, m_right}); end
            n_checks++; if (bus.scan_code !== m_code) begin n_errors++; $display("FAIL rnd_scan[%0d]: got %h expected %h", i, bus.scan_code, m_code); end
            n_checks++; if (n_valid !== m_valid || n_err !== m_err) begin n_errors++; $display("FAIL rnd_pulses[%0d]: got valid=%0d err=%0d expected valid=%0d err=%0d", i, n_valid, n_err, m_valid, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
